pipeline_hazard_ctrl: RTL and testbench

Central hazard and stall controller for the five-stage RV32I pipeline. Generates stall, flush and write-enable controls for the IF, IF/ID, ID/EX and EX/MEM/WB stages. Generates operand-forwarding selects for the EX stage. Sequences multi-cycle data-memory accesses through a wait FSM with timeout, and keeps saturating stall and flush event counters for debug.

---
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage RV32I pipeline.
// Produces stall/flush/freeze controls, EX operand-forwarding selects,
// a data-memory wait FSM with timeout trap, and saturating debug counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic [4:0]       rdM,
  input  logic             RegWriteM,
  input  logic [4:0]       rdW,
  input  logic             RegWriteW,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             IF_ID_Write,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FreezeEMW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } state_t;

  localparam logic [7:0] WLAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] wcnt, wcnt_nx;
  logic       lw_stall;
  logic       mem_stall;

  // EX operand forwarding; the MEM result is younger and wins over WB
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && rdM != 5'd0 && rdM == rs1E)
      ForwardAE = 2'b10;
    else if (RegWriteW && rdW != 5'd0 && rdW == rs1E)
      ForwardAE = 2'b01;
    if (RegWriteM && rdM != 5'd0 && rdM == rs2E)
      ForwardBE = 2'b10;
    else if (RegWriteW && rdW != 5'd0 && rdW == rs2E)
      ForwardBE = 2'b01;
  end

  // Load-use hazard detection between EX load and ID consumer
  always_comb begin
    lw_stall = ResultSrcE0 && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
  end

  // Data-memory wait FSM next state and memory stall.
  // The stall is released in the WAIT cycle where dmem_ready arrives, so an
  // access completing at wait cycle N costs exactly N stall cycles.
  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (dmem_req && !dmem_ready) begin
          mem_stall = 1'b1;
          state_nx  = WAIT;
          wcnt_nx   = 8'd1;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_nx = IDLE;
        end else begin
          mem_stall = 1'b1;
          if (wcnt == WLAST)
            state_nx = ERR;
          else
            wcnt_nx = wcnt + 8'd1;
        end
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Pipeline control outputs; a memory stall freezes everything and
  // suppresses flushes until it clears
  always_comb begin
    StallF      = lw_stall || mem_stall;
    IF_ID_Write = !(lw_stall || mem_stall);
    FlushD      = PCSrcE && !mem_stall;
    FlushE      = (lw_stall || PCSrcE) && !mem_stall;
    FreezeEMW   = mem_stall;
  end

  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (state_nx == ERR)
        mem_err <= 1'b1;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (FlushD && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, dmem_req, dmem_ready;
  logic       StallF, IF_ID_Write, FlushD, FlushE, FreezeEMW, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .rdM(rdM), .RegWriteM(RegWriteM), .rdW(rdW), .RegWriteW(RegWriteW),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .StallF(StallF), .IF_ID_Write(IF_ID_Write), .FlushD(FlushD),
    .FlushE(FlushE), .FreezeEMW(FreezeEMW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stallf, ifid, flushd, flushe, freeze;
    logic [1:0] fa, fb;
    logic       err;
    logic [3:0] sc, fc;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t E(input logic st, input logic iw, input logic fd,
                             input logic fe, input logic fz, input logic [1:0] fa,
                             input logic [1:0] fb, input logic er,
                             input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.stallf = st; e.ifid = iw; e.flushd = fd; e.flushe = fe; e.freeze = fz;
    e.fa = fa; e.fb = fb; e.err = er; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("StallF",      {3'b0, StallF},      {3'b0, e.stallf});
        chk("IF_ID_Write", {3'b0, IF_ID_Write}, {3'b0, e.ifid});
        chk("FlushD",      {3'b0, FlushD},      {3'b0, e.flushd});
        chk("FlushE",      {3'b0, FlushE},      {3'b0, e.flushe});
        chk("FreezeEMW",   {3'b0, FreezeEMW},   {3'b0, e.freeze});
        chk("ForwardAE",   {2'b0, ForwardAE},   {2'b0, e.fa});
        chk("ForwardBE",   {2'b0, ForwardBE},   {2'b0, e.fb});
        chk("mem_err",     {3'b0, mem_err},     {3'b0, e.err});
        chk("stall_cnt",   stall_cnt,           e.sc);
        chk("flush_cnt",   flush_cnt,           e.fc);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    nxt();
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,0,0));   // reset state
    nxt(); rst = 1'b0;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,0,0));

    // Forwarding A
    nxt(); rdM = 5; rdW = 5; rs1E = 5; RegWriteM = 1; RegWriteW = 1;
    sb.push_back(E(0,1,0,0,0,2'b10,2'b00,0,0,0));
    nxt(); RegWriteM = 0;
    sb.push_back(E(0,1,0,0,0,2'b01,2'b00,0,0,0));
    nxt(); rdM = 0; rdW = 0; rs1E = 0; RegWriteM = 1;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,0,0));
    // Forwarding B
    nxt(); rs1E = 3; rs2E = 9; rdM = 9; rdW = 9; RegWriteM = 1; RegWriteW = 1;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b10,0,0,0));
    nxt(); rdM = 4;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b01,0,0,0));
    nxt(); rdM = 3;
    sb.push_back(E(0,1,0,0,0,2'b10,2'b01,0,0,0));

    // Load-use
    nxt(); clear_in(); ResultSrcE0 = 1; rdE = 7; rs2D = 7;
    sb.push_back(E(1,0,0,1,0,2'b00,2'b00,0,0,0));
    nxt(); clear_in();
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,1,0));
    // Load of x0 is never a hazard
    nxt(); ResultSrcE0 = 1; rdE = 0; rs1D = 0;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,1,0));

    // Branch
    nxt(); clear_in(); PCSrcE = 1;
    sb.push_back(E(0,1,1,1,0,2'b00,2'b00,0,1,0));
    nxt(); clear_in();
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,1,1));
    // Branch together with load-use
    nxt(); PCSrcE = 1; ResultSrcE0 = 1; rdE = 7; rs1D = 7;
    sb.push_back(E(1,0,1,1,0,2'b00,2'b00,0,1,1));
    nxt(); clear_in();
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,2,2));

    // Zero-wait access
    nxt(); dmem_req = 1; dmem_ready = 1;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,2,2));

    // Three wait cycles with a taken branch held in EX
    nxt(); dmem_ready = 0; PCSrcE = 1;
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,0,2,2));
    nxt();
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,0,3,2));
    nxt();
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,0,4,2));
    nxt(); dmem_ready = 1;
    sb.push_back(E(0,1,1,1,0,2'b00,2'b00,0,5,2));
    nxt(); clear_in();
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,5,3));

    // Timeout into ERR
    nxt(); dmem_req = 1;
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,0,5,3));
    nxt();
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,0,6,3));
    nxt();
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,0,7,3));
    nxt();
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,0,8,3));
    nxt(); dmem_req = 0;
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,1,9,3));
    nxt(); PCSrcE = 1;
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,1,10,3));
    // Asynchronous reset out of ERR
    nxt(); clear_in(); rst = 1;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,0,0));
    nxt(); rst = 0;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,0,0));

    // Reset mid-WAIT releases the stall immediately
    nxt(); dmem_req = 1;
    sb.push_back(E(1,0,0,0,1,2'b00,2'b00,0,0,0));
    nxt(); dmem_req = 0; rst = 1;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,0,0));
    nxt(); rst = 0;
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,0,0));

    // Saturation of the stall counter
    for (int k = 0; k < 20; k++) begin
      nxt(); ResultSrcE0 = 1; rdE = 2; rs1D = 2;
      sb.push_back(E(1,0,0,1,0,2'b00,2'b00,0,(k < 15) ? 4'(k) : 4'd15,0));
    end
    nxt(); clear_in();
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,15,0));
    nxt();
    sb.push_back(E(0,1,0,0,0,2'b00,2'b00,0,15,0));

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
